// File: rtl/stream_reorder_pkg.sv
// rtl/stream_reorder_pkg.sv - shared types, FIFO depth and width check for stream_reorder_pipe
package stream_reorder_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_SLICE  = 2'b01,
    MODE_DSLICE = 2'b10,
    MODE_BITREV = 2'b11
  } reorder_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  localparam int RFIFO_DEPTH = 2;

  // Payload must split into a whole number of double slices.
  function automatic bit widths_ok(input int data_w, input int slice_w);
    if (slice_w < 1 || data_w < 1) return 1'b0;
    return (data_w % (2 * slice_w)) == 0;
  endfunction

endpackage

// File: rtl/stream_reorder_pipe_if.sv
// rtl/stream_reorder_pipe_if.sv - producer/consumer handshake bundle for stream_reorder_pipe
interface stream_reorder_pipe_if
  import stream_reorder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
);

  logic                    in_valid;
  logic                    in_ready;
  reorder_mode_e           in_mode;
  logic [TAG_W-1:0]        in_tag;
  logic [DATA_W-1:0]       in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [TAG_W+DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_mode, in_tag, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_tag, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/stream_reorder_fn.sv
// rtl/stream_reorder_fn.sv - combinational mode mux over the streaming reorder operators
module stream_reorder_fn
  import stream_reorder_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SLICE_W = 4
) (
  input  reorder_mode_e     mode,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result
);

  localparam int DSLICE_W = 2 * SLICE_W;

  always_comb begin
    result = data;
    unique case (mode)
      MODE_PASS:   result = data;
      MODE_SLICE:  result = {<<SLICE_W{data}};
      MODE_DSLICE: result = {<<DSLICE_W{data}};
      MODE_BITREV: result = {<<{data}};
      default:     result = data;
    endcase
  end

endmodule

// File: rtl/stream_reorder_pipe.sv
// rtl/stream_reorder_pipe.sv - tagged reorder stage with 2-entry registered FIFO; optional STREAM_REORDER_STATS_EN counter
module stream_reorder_pipe
  import stream_reorder_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SLICE_W = 4,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stream_reorder_pipe_if.slave bus
`ifdef STREAM_REORDER_STATS_EN
  ,
  output logic [15:0]          xfer_cnt
`endif
);

  localparam int ENTRY_W = TAG_W + DATA_W;

  generate
    if (!widths_ok(DATA_W, SLICE_W) || TAG_W < 1) begin : g_bad_widths
      $error("stream_reorder_pipe: DATA_W must be a multiple of 2*SLICE_W, SLICE_W>=1, TAG_W>=1");
    end
  endgenerate

  logic [ENTRY_W-1:0] mem [RFIFO_DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  fifo_state_e        state;
  fifo_state_e        state_nx;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  reordered;

  stream_reorder_fn #(
    .DATA_W  (DATA_W),
    .SLICE_W (SLICE_W)
  ) u_fn (
    .mode   (bus.in_mode),
    .data   (bus.in_data),
    .result (reordered)
  );

  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = mem[rd_ptr];

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY:   if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = FULL;
        else if (pop && !push) state_nx = EMPTY;
      end
      FULL:    if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < RFIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nx;
      if (push) begin
        mem[wr_ptr] <= {bus.in_tag, reordered};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

`ifdef STREAM_REORDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    xfer_cnt <= '0;
    else if (push) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_stream_reorder_pipe.sv
// tb/tb_stream_reorder_pipe.sv - randomized bench for stream_reorder_pipe against a queue model
module tb_stream_reorder_pipe;
  import stream_reorder_pkg::*;

  localparam int DW = 16;
  localparam int SW = 4;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_reorder_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

`ifdef STREAM_REORDER_STATS_EN
  logic [15:0] xfer_cnt;
`endif

  stream_reorder_pipe #(
    .DATA_W  (DW),
    .SLICE_W (SW),
    .TAG_W   (TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef STREAM_REORDER_STATS_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [TW+DW-1:0] q[$];
  int unsigned push_total = 0;
  logic last_accepted = 1'b0;
  logic [TW+DW-1:0] mode_tab [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slice i of the result is slice (n-1-i) of the input; w=1 is a bit reverse.
  function automatic logic [DW-1:0] ref_reorder(input logic [DW-1:0] d, input reorder_mode_e m);
    int w;
    logic [DW-1:0] r;
    r = '0;
    case (m)
      MODE_PASS:   return d;
      MODE_SLICE:  w = SW;
      MODE_DSLICE: w = 2 * SW;
      default:     w = 1;
    endcase
    for (int b = 0; b < DW; b++) r[b] = d[(DW / w - 1 - b / w) * w + b % w];
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    check("out_valid", bus.out_valid, q.size() != 0);
    check("in_ready", bus.in_ready, q.size() < 2);
    if (q.size() != 0) check("out_data", bus.out_data, q[0]);
    last_accepted = bus.in_valid && (q.size() < 2);
    if (bus.out_ready && q.size() != 0) void'(q.pop_front());
    if (last_accepted) begin
      q.push_back({bus.in_tag, ref_reorder(bus.in_data, bus.in_mode)});
      push_total++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [TW-1:0] t, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.in_mode  = reorder_mode_e'(m);
    bus.in_tag   = t;
    bus.in_data  = d;
  endtask

  task automatic drive_rand();
    drive(1'b1, 2'($urandom_range(0, 3)), TW'($urandom), DW'($urandom));
  endtask

  task automatic send_held();
    int guard;
    guard = 0;
    tick();
    while (!last_accepted && guard < 20) begin
      tick();
      guard++;
    end
    if (!last_accepted) check("send_timeout", 1, 0);
  endtask

  task automatic check_stats();
`ifdef STREAM_REORDER_STATS_EN
    check("xfer_cnt", xfer_cnt, push_total % 65536);
`endif
  endtask

  initial begin
    mode_tab[0] = 20'h41234;
    mode_tab[1] = 20'h44321;
    mode_tab[2] = 20'h43412;
    mode_tab[3] = 20'h42C48;

    rst_n = 1'b0;
    drive(1'b0, 2'd0, '0, '0);
    bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_data", bus.out_data, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_stats();

    // Fixed-vector mode table
    bus.out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 2'(m), 4'h4, 16'h1234);
      tick();
      bus.in_valid = 1'b0;
      check("mode_const", bus.out_data, mode_tab[m]);
      tick();
    end

    // Backpressure: two fill the FIFO, the third stalls until release
    bus.out_ready = 1'b0;
    drive_rand(); send_held();
    drive_rand(); send_held();
    drive_rand();
    tick();
    tick();
    check("stall_in_ready", bus.in_ready, 0);
    check("stall_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    send_held();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Back-to-back streaming with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      drive_rand();
      tick();
      check("stream_valid", bus.out_valid, 1);
      check("stream_ready", bus.in_ready, 1);
    end
    bus.in_valid = 1'b0;
    tick();
    check_stats();

    // Random traffic, producer holds a stalled word
    bus.in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(bus.in_valid && !last_accepted)) begin
        drive_rand();
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_stats();

    // Asynchronous reset with the FIFO full
    bus.out_ready = 1'b0;
    drive_rand(); send_held();
    drive_rand(); send_held();
    bus.in_valid = 1'b0;
    tick();
    check("full_before_rst", bus.in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_data", bus.out_data, 0);
    q.delete();
    push_total = 0;
    check_stats();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    drive_rand();
    tick();
    bus.in_valid = 1'b0;
    tick();
    check_stats();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
